// File: rtl/store_unit_m.sv
// -----------------------------------------------------------------------------
// store_unit_m
// MEM-stage store engine. Captures a store (SB/SH/SW), lane-aligns the data,
// builds byte enables and drives a single request/acknowledge write to data
// memory. The pipeline is stalled until the write is acknowledged or the
// request times out.
//
// Optional feature macro: STORE_MISALIGN_TRAP_EN
//   When defined, misaligned halves/words are not issued to memory. They go
//   straight to DONE and raise oMisaligned together with oStoreDone.
//   When undefined, low address bits are ignored for half/word stores and
//   oMisaligned is constant 0.
// -----------------------------------------------------------------------------
module store_unit_m #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iStoreValidM,
    input  logic [1:0]        iStoreTypeM,
    input  logic [ADDR_W-1:0] iAddrM,
    input  logic [31:0]       iWriteDataM,
    input  logic              iMemAck,
    output logic              oMemReq,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [31:0]       oMemWData,
    output logic [3:0]        oMemByteEn,
    output logic              oStallM,
    output logic              oStoreDone,
    output logic              oBusErr,
    output logic              oMisaligned
);

    // Counter only needs to reach TIMEOUT_CYCLES-1; a zero timeout never fires.
    localparam int unsigned     CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             TMO_EN    = (TIMEOUT_CYCLES != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Replicate the store data across all lanes so any enabled lane sees it.
    function automatic logic [31:0] align_wdata(input logic [1:0] st, input logic [31:0] d);
        logic [31:0] w;
        case (st)
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Byte enables from access size and low address bits (half ignores a[0]).
    function automatic logic [3:0] align_be(input logic [1:0] st, input logic [1:0] a);
        logic [3:0] be;
        case (st)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = 4'b0011 << {a[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

`ifdef STORE_MISALIGN_TRAP_EN
    // Half on an odd address, or word/11 on a non-word address.
    function automatic logic is_misaligned(input logic [1:0] st, input logic [1:0] a);
        logic m;
        case (st)
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            default: m = (a != 2'b00) ? 1'b1 : 1'b0;
        endcase
        return m;
    endfunction
`endif

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic               capture_s;
    logic               set_err_s;
    logic               set_mis_s;
    logic               stall_s;
    logic               req_r;
    logic               done_r;
    logic               buserr_r;
    logic               mis_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [31:0]        wdata_r;
    logic [3:0]         be_r;

    // Next-state, capture strobe, error/trap flags and pipeline stall.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        set_err_s = 1'b0;
        set_mis_s = 1'b0;
        stall_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (iStoreValidM) begin
                    stall_s = 1'b1;
`ifdef STORE_MISALIGN_TRAP_EN
                    if (is_misaligned(iStoreTypeM, iAddrM[1:0])) begin
                        state_s   = ST_DONE;
                        set_mis_s = 1'b1;
                    end else begin
                        state_s   = ST_REQ;
                        capture_s = 1'b1;
                    end
`else
                    state_s   = ST_REQ;
                    capture_s = 1'b1;
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                stall_s = 1'b1;
                if (iMemAck) begin
                    // Ack wins over a coincident timeout.
                    state_s = ST_DONE;
                end else if (TMO_EN && (cnt_r == CNT_LAST)) begin
                    state_s   = ST_DONE;
                    set_err_s = 1'b1;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Timeout counter: counts consecutive REQ cycles, cleared on leaving REQ.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_REQ) && (state_s == ST_REQ)) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Registered handshake/status outputs, decoded from the next state.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            req_r    <= 1'b0;
            done_r   <= 1'b0;
            buserr_r <= 1'b0;
            mis_r    <= 1'b0;
        end else begin
            req_r    <= (state_s == ST_REQ)  ? 1'b1 : 1'b0;
            done_r   <= (state_s == ST_DONE) ? 1'b1 : 1'b0;
            buserr_r <= set_err_s;
            mis_r    <= set_mis_s;
        end
    end

    // Write address/data/enables: loaded on acceptance, held otherwise.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= 32'h0000_0000;
            be_r    <= 4'b0000;
        end else if (capture_s) begin
            addr_r  <= {iAddrM[ADDR_W-1:2], 2'b00};
            wdata_r <= align_wdata(iStoreTypeM, iWriteDataM);
            be_r    <= align_be(iStoreTypeM, iAddrM[1:0]);
        end else begin
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
            be_r    <= be_r;
        end
    end

    assign oMemReq     = req_r;
    assign oMemAddr    = addr_r;
    assign oMemWData   = wdata_r;
    assign oMemByteEn  = be_r;
    assign oStallM     = stall_s;
    assign oStoreDone  = done_r;
    assign oBusErr     = buserr_r;
    assign oMisaligned = mis_r;

endmodule

// File: tb/tb_store_unit_m.sv
// -----------------------------------------------------------------------------
// tb_store_unit_m
// Self-checking bench for store_unit_m (TIMEOUT_CYCLES=8). Expected lane data,
// enables, request length and error flags come from a size/offset model.
// Honours STORE_MISALIGN_TRAP_EN when the design is built with it.
// -----------------------------------------------------------------------------
module tb_store_unit_m;

    localparam int unsigned TMO = 8;
    localparam int unsigned AW  = 32;

    logic          iClk = 1'b0;
    logic          iRstN;
    logic          iStoreValidM;
    logic [1:0]    iStoreTypeM;
    logic [AW-1:0] iAddrM;
    logic [31:0]   iWriteDataM;
    logic          iMemAck;
    logic          oMemReq;
    logic [AW-1:0] oMemAddr;
    logic [31:0]   oMemWData;
    logic [3:0]    oMemByteEn;
    logic          oStallM;
    logic          oStoreDone;
    logic          oBusErr;
    logic          oMisaligned;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int req_start_cyc = 0;

    logic [31:0] last_addr  = 32'h0;
    logic [31:0] last_wdata = 32'h0;
    logic [3:0]  last_be    = 4'h0;

    store_unit_m #(.TIMEOUT_CYCLES(TMO), .ADDR_W(AW)) dut (
        .iClk(iClk), .iRstN(iRstN), .iStoreValidM(iStoreValidM),
        .iStoreTypeM(iStoreTypeM), .iAddrM(iAddrM), .iWriteDataM(iWriteDataM),
        .iMemAck(iMemAck), .oMemReq(oMemReq), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .oMemByteEn(oMemByteEn), .oStallM(oStallM),
        .oStoreDone(oStoreDone), .oBusErr(oBusErr), .oMisaligned(oMisaligned)
    );

    always #5 iClk = ~iClk;

    // Free-running cycle counter for request spacing.
    always @(posedge iClk) cyc <= cyc + 1;

    // Reference: access of sz bytes sits at the sz-aligned offset in the word;
    // lane i carries data byte (i mod sz).
    function automatic void model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] ew, output logic [3:0] eb, output logic [31:0] ea);
        int sz;
        int off;
        int base;
        sz   = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
        off  = int'(a % 32'd4);
        base = (off / sz) * sz;
        ea   = a - (a % 32'd4);
        eb   = 4'b0000;
        ew   = 32'h0;
        for (int i = 0; i < 4; i++) begin
            eb[i]        = (i >= base && i < base + sz) ? 1'b1 : 1'b0;
            ew[8*i +: 8] = 8'((d >> (8 * (i % sz))) & 32'hFF);
        end
    endfunction

    function automatic logic model_mis(input logic [1:0] t, input logic [31:0] a);
        int sz;
        sz = (t == 2'd0) ? 1 : (t == 2'd1) ? 2 : 4;
        return ((a % 32'(sz)) != 32'd0) ? 1'b1 : 1'b0;
    endfunction

    // One store: capture cycle, modelled REQ cycles with ack at ack_idx, DONE.
    task automatic run_store(input logic [1:0] t, input logic [31:0] a, input logic [31:0] d,
                             input int ack_idx, input string tag);
        logic [31:0] ew;
        logic [31:0] ea;
        logic [3:0]  eb;
        int          exp_n;
        logic        exp_err;
        logic        exp_mis;
        model(t, a, d, ew, eb, ea);
        exp_n   = (ack_idx < int'(TMO)) ? ack_idx + 1 : int'(TMO);
        exp_err = (ack_idx < int'(TMO)) ? 1'b0 : 1'b1;
        exp_mis = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
        if (model_mis(t, a)) begin
            exp_mis = 1'b1;
            exp_n   = 0;
            exp_err = 1'b0;
        end
`endif
        @(posedge iClk); #1;
        iStoreValidM = 1'b1; iStoreTypeM = t; iAddrM = a; iWriteDataM = d; iMemAck = 1'b0;
        #1;
        checks++;
        if (oStallM !== 1'b1 || oMemReq !== 1'b0 || oStoreDone !== 1'b0) begin
            $display("FAIL %s capture: stall=%b req=%b done=%b, want 1 0 0", tag, oStallM, oMemReq, oStoreDone);
            errors++;
        end
        for (int k = 0; k < exp_n; k++) begin
            @(posedge iClk); #1;
            iMemAck = (k == ack_idx) ? 1'b1 : 1'b0;
            #1;
            if (k == 0) req_start_cyc = cyc;
            checks++;
            if (oMemReq !== 1'b1 || oStallM !== 1'b1 || oStoreDone !== 1'b0) begin
                $display("FAIL %s req%0d: req=%b stall=%b done=%b, want 1 1 0", tag, k, oMemReq, oStallM, oStoreDone);
                errors++;
            end
            checks++;
            if (oMemAddr !== ea || oMemWData !== ew || oMemByteEn !== eb) begin
                $display("FAIL %s req%0d data: addr=%h wd=%h be=%b, want %h %h %b", tag, k, oMemAddr, oMemWData, oMemByteEn, ea, ew, eb);
                errors++;
            end
        end
        @(posedge iClk); #1;
        iMemAck = 1'b0;
        #1;
        checks++;
        if (oStoreDone !== 1'b1 || oMemReq !== 1'b0 || oStallM !== 1'b0 || oBusErr !== exp_err || oMisaligned !== exp_mis) begin
            $display("FAIL %s done: done=%b req=%b stall=%b err=%b mis=%b, want 1 0 0 %b %b",
                     tag, oStoreDone, oMemReq, oStallM, oBusErr, oMisaligned, exp_err, exp_mis);
            errors++;
        end
        if (!exp_mis) begin
            last_addr = ea; last_wdata = ew; last_be = eb;
        end
    endtask

    // Non-store cycles: nothing requested, no stall, outputs hold.
    task automatic idle_gap(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge iClk); #1;
            iStoreValidM = 1'b0; iMemAck = 1'b0; iAddrM = $urandom; iWriteDataM = $urandom;
            #1;
            checks++;
            if (oMemReq !== 1'b0 || oStallM !== 1'b0 || oStoreDone !== 1'b0 || oBusErr !== 1'b0 || oMisaligned !== 1'b0) begin
                $display("FAIL %s idle%0d: req=%b stall=%b done=%b err=%b mis=%b, want all 0",
                         tag, k, oMemReq, oStallM, oStoreDone, oBusErr, oMisaligned);
                errors++;
            end
            checks++;
            if (oMemAddr !== last_addr || oMemWData !== last_wdata || oMemByteEn !== last_be) begin
                $display("FAIL %s hold%0d: addr=%h wd=%h be=%b, want %h %h %b",
                         tag, k, oMemAddr, oMemWData, oMemByteEn, last_addr, last_wdata, last_be);
                errors++;
            end
        end
    endtask

    task automatic test_reset();
        iRstN = 1'b0; iStoreValidM = 1'b0; iStoreTypeM = 2'b00; iAddrM = 32'h0;
        iWriteDataM = 32'h0; iMemAck = 1'b0;
        #3;
        checks++;
        if (oMemReq !== 1'b0 || oStoreDone !== 1'b0 || oBusErr !== 1'b0 || oMisaligned !== 1'b0 ||
            oStallM !== 1'b0 || oMemAddr !== 32'h0 || oMemWData !== 32'h0 || oMemByteEn !== 4'h0) begin
            $display("FAIL reset: req=%b done=%b err=%b mis=%b stall=%b addr=%h wd=%h be=%b, want all 0",
                     oMemReq, oStoreDone, oBusErr, oMisaligned, oStallM, oMemAddr, oMemWData, oMemByteEn);
            errors++;
        end
        @(posedge iClk); @(posedge iClk); #1;
        iRstN = 1'b1;
        last_addr = 32'h0; last_wdata = 32'h0; last_be = 4'h0;
        idle_gap(2, "post_reset");
    endtask

    task automatic test_plan_vectors();
        run_store(2'b00, 32'h0000_1003, 32'hAABB_CCDD, 0, "sb_1003");
        idle_gap(1, "sb_gap");
        checks++;
        if (oMemAddr !== 32'h0000_1000 || oMemWData !== 32'hDDDD_DDDD || oMemByteEn !== 4'b1000) begin
            $display("FAIL sb_vector: addr=%h wd=%h be=%b, want 00001000 dddddddd 1000", oMemAddr, oMemWData, oMemByteEn);
            errors++;
        end
        run_store(2'b01, 32'h0000_2002, 32'h0000_1234, 3, "sh_2002");
        idle_gap(1, "sh_gap");
        checks++;
        if (oMemAddr !== 32'h0000_2000 || oMemWData !== 32'h1234_1234 || oMemByteEn !== 4'b1100) begin
            $display("FAIL sh_vector: addr=%h wd=%h be=%b, want 00002000 12341234 1100", oMemAddr, oMemWData, oMemByteEn);
            errors++;
        end
    endtask

    task automatic test_timeout();
        run_store(2'b10, 32'h0000_3000, 32'hCAFE_F00D, 1000, "sw_timeout");
        run_store(2'b10, 32'h0000_3004, 32'h1357_9BDF, 1, "sw_after_timeout");
        run_store(2'b10, 32'h0000_3008, 32'h2468_ACE0, int'(TMO) - 1, "ack_at_limit");
        idle_gap(1, "timeout_gap");
    endtask

    task automatic test_back_to_back();
        int s1;
        run_store(2'b10, 32'h0000_5000, 32'h1111_1111, 0, "b2b_first");
        s1 = req_start_cyc;
        run_store(2'b10, 32'h0000_5004, 32'h2222_2222, 0, "b2b_second");
        checks++;
        if (req_start_cyc - s1 !== 3) begin
            $display("FAIL b2b_spacing: got %0d cycles, want 3", req_start_cyc - s1);
            errors++;
        end
        idle_gap(1, "b2b_gap");
    endtask

    task automatic test_reset_mid_req();
        @(posedge iClk); #1;
        iStoreValidM = 1'b1; iStoreTypeM = 2'b10; iAddrM = 32'h0000_6000; iWriteDataM = 32'h5A5A_5A5A; iMemAck = 1'b0;
        @(posedge iClk); #2;
        @(posedge iClk); #1;
        iRstN = 1'b0; iStoreValidM = 1'b0;
        #1;
        checks++;
        if (oMemReq !== 1'b0 || oStoreDone !== 1'b0 || oMemAddr !== 32'h0) begin
            $display("FAIL rst_mid_req: req=%b done=%b addr=%h, want 0 0 0", oMemReq, oStoreDone, oMemAddr);
            errors++;
        end
        @(posedge iClk); #2;
        checks++;
        if (oMemReq !== 1'b0 || oStoreDone !== 1'b0) begin
            $display("FAIL rst_hold: req=%b done=%b, want 0 0", oMemReq, oStoreDone);
            errors++;
        end
        iRstN = 1'b1;
        last_addr = 32'h0; last_wdata = 32'h0; last_be = 4'h0;
        idle_gap(1, "rst_release");
        run_store(2'b10, 32'h0000_6000, 32'h5A5A_5A5A, 1, "reissue");
        idle_gap(1, "reissue_gap");
    endtask

    task automatic test_misalign();
        run_store(2'b10, 32'h0000_4001, 32'h8765_4321, 0, "sw_4001");
        idle_gap(1, "mis_gap");
`ifndef STORE_MISALIGN_TRAP_EN
        checks++;
        if (oMemByteEn !== 4'b1111 || oMemAddr !== 32'h0000_4000 || oMemWData !== 32'h8765_4321) begin
            $display("FAIL sw_4001_vector: addr=%h wd=%h be=%b, want 00004000 87654321 1111", oMemAddr, oMemWData, oMemByteEn);
            errors++;
        end
`endif
        run_store(2'b01, 32'h0000_4003, 32'h0000_BEEF, 2, "sh_4003");
        idle_gap(1, "mis_gap2");
    endtask

    task automatic test_random();
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] d;
        int          ack;
        for (int n = 0; n < 40; n++) begin
            t   = 2'($urandom_range(0, 3));
            a   = $urandom;
            d   = $urandom;
            ack = int'($urandom_range(0, 10));
            run_store(t, a, d, ack, "random");
            idle_gap(int'($urandom_range(0, 2)), "random_gap");
        end
    endtask

    initial begin
        test_reset();
        test_plan_vectors();
        test_timeout();
        test_back_to_back();
        test_reset_mid_req();
        test_misalign();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
